// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALUOp and mux selects.
// The TRAP state exists only when MAIN_CTRL_ILLEGAL_TRAP_EN is defined.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, UPPER
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_UPPER = 2'b11;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Control bundle between the main FSM (master) and the multicycle datapath (slave).
interface main_ctrl_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       pc_update;
  logic       reg_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] ALUOp;
  logic       illegal_instr;

  modport master (
    input  op, funct3, zero, lt, mem_ready,
    output mem_req, mem_write, ir_write, pc_update, reg_write,
           adr_src, alu_src_a, alu_src_b, result_src, ALUOp, illegal_instr
  );

  modport slave (
    output op, funct3, zero, lt, mem_ready,
    input  mem_req, mem_write, ir_write, pc_update, reg_write,
           adr_src, alu_src_a, alu_src_b, result_src, ALUOp, illegal_instr
  );
endinterface

// File: rtl/branch_cond.sv
// Branch outcome from funct3 and the ALU compare flags (zero for eq/ne, lt for signed/unsigned lt/ge).
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       take
);
  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:         take = zero;
      3'b001:         take = !zero;
      3'b100, 3'b110: take = lt;
      3'b101, 3'b111: take = !lt;
      default:        take = 1'b0;
    endcase
  end
endmodule

// File: rtl/main_ctrl_fsm.sv
// Moore control FSM for a multicycle RV32I datapath.
// MAIN_CTRL_ILLEGAL_TRAP_EN: undefined opcodes park in TRAP with a sticky illegal_instr; otherwise they are NOPs.
module main_ctrl_fsm
  import rv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  main_ctrl_fsm_if.master  bus
);

  state_e     state_q, state_d;
  logic       take;
  logic       mem_req, mem_write, ir_write, pc_update, reg_write, adr_src;
  logic [1:0] src_a, src_b, res_src, alu_op;

  branch_cond u_branch_cond (
    .funct3 (bus.funct3),
    .zero   (bus.zero),
    .lt     (bus.lt),
    .take   (take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    reg_write = 1'b0;
    adr_src   = ADR_PC;
    src_a     = SRCA_PC;
    src_b     = SRCB_RS2;
    res_src   = RES_ALUOUT;
    alu_op    = ALUOP_ADD;
    unique case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        src_b     = SRCB_FOUR;
        res_src   = RES_ALU;
        ir_write  = bus.mem_ready;
        pc_update = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // PC+imm lands in ALUOut here so BRANCH/JAL find their target ready
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI, OP_AUIPC:  state_d = UPPER;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          default:           state_d = TRAP;
`else
          default:           state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        state_d = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = ADR_ALUOUT;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        res_src   = RES_RDATA;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = ADR_ALUOUT;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXECR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECI: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        src_a     = SRCA_RS1;
        src_b     = SRCB_RS2;
        alu_op    = ALUOP_BR;
        pc_update = take;
        state_d   = FETCH;
      end
      JALR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        state_d = JAL;
      end
      JAL: begin
        // target already in ALUOut; ALU computes oldPC+4 for the link write
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      UPPER: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_UPPER;
        state_d = ALUWB;
      end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase

    // state is already FETCH in reset, but its memory request must not leak out
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_update = 1'b0;
      reg_write = 1'b0;
      adr_src   = ADR_PC;
      src_a     = SRCA_PC;
      src_b     = SRCB_FOUR;
      res_src   = RES_ALU;
      alu_op    = ALUOP_ADD;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.pc_update  = pc_update;
  assign bus.reg_write  = reg_write;
  assign bus.adr_src    = adr_src;
  assign bus.alu_src_a  = src_a;
  assign bus.alu_src_b  = src_b;
  assign bus.result_src = res_src;
  assign bus.ALUOp      = alu_op;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  // TRAP is only left through reset, so decoding it is already sticky
  assign bus.illegal_instr = (state_q == TRAP);
`else
  assign bus.illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm: per-instruction cycle counts, strobe pulses and reset behaviour.
module tb_main_ctrl_fsm;
  import rv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  main_ctrl_fsm_if bus();
  main_ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  state_e     seq [16];
  logic [1:0] aop [16];
  logic       rwv [16];
  logic       pcv [16];
  int ncyc, nrw, npc, nmw;

  // Runs one instruction from FETCH; stalls the first `stall` cycles of the data-memory state.
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic z, input logic l,
                     input int stall, input int maxc);
    int left;
    left = stall;
    bus.op = o; bus.funct3 = f3; bus.zero = z; bus.lt = l;
    ncyc = 0; nrw = 0; npc = 0; nmw = 0;
    for (int i = 0; i < maxc; i++) begin
      bus.mem_ready = 1'b1;
      if (bus.mem_req && bus.adr_src && left > 0) begin
        bus.mem_ready = 1'b0;
        left--;
      end
      #1;
      if (i < 16) begin
        seq[i] = dut.state_q; aop[i] = bus.ALUOp;
        rwv[i] = bus.reg_write; pcv[i] = bus.pc_update;
      end
      ncyc++;
      nrw += int'(bus.reg_write);
      npc += int'(bus.pc_update);
      nmw += int'(bus.mem_write);
      nxt();
      if (dut.state_q == FETCH) break;
    end
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    bus.op = OP_RTYPE; bus.funct3 = 3'b000; bus.zero = 1'b0; bus.lt = 1'b0; bus.mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(dut.state_q), 32'(FETCH));
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
    chk("rst_pc_update", 32'(bus.pc_update), 32'd0);
    chk("rst_alu_src_b", 32'(bus.alu_src_b), 32'd2);
    chk("rst_result_src", 32'(bus.result_src), 32'd2);
    chk("rst_illegal", 32'(bus.illegal_instr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // FETCH holds while memory is not ready
    bus.mem_ready = 1'b0;
    #1;
    chk("fetch_stall_irw", 32'(bus.ir_write), 32'd0);
    chk("fetch_stall_req", 32'(bus.mem_req), 32'd1);
    nxt();
    chk("fetch_stall_hold", 32'(dut.state_q), 32'(FETCH));
    bus.mem_ready = 1'b1;

    run(OP_RTYPE, 3'b000, 1'b0, 1'b0, 0, 12);
    chk("add_cycles", 32'(ncyc), 32'd4);
    chk("add_rw_count", 32'(nrw), 32'd1);
    chk("add_rw_c4", 32'(rwv[3]), 32'd1);
    chk("add_execr", 32'(seq[2]), 32'(EXECR));
    chk("add_aluop", 32'(aop[2]), 32'd2);
    chk("add_fetch_pc", 32'(pcv[0]), 32'd1);

    run(OP_ITYPE, 3'b000, 1'b0, 1'b0, 0, 12);
    chk("addi_cycles", 32'(ncyc), 32'd4);
    chk("addi_execi", 32'(seq[2]), 32'(EXECI));

    run(OP_LOAD, 3'b010, 1'b0, 1'b0, 3, 16);
    chk("lw_stall_cycles", 32'(ncyc), 32'd8);
    chk("lw_stall_rw", 32'(nrw), 32'd1);
    chk("lw_memread_last", 32'(seq[6]), 32'(MEMREAD));
    chk("lw_memwb", 32'(seq[7]), 32'(MEMWB));
    chk("lw_rw_memwb", 32'(rwv[7]), 32'd1);

    run(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 12);
    chk("lw_cycles", 32'(ncyc), 32'd5);

    run(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 12);
    chk("sw_cycles", 32'(ncyc), 32'd4);
    chk("sw_mem_write", 32'(nmw), 32'd1);
    chk("sw_no_rw", 32'(nrw), 32'd0);

    run(OP_STORE, 3'b010, 1'b0, 1'b0, 2, 12);
    chk("sw_stall_cycles", 32'(ncyc), 32'd6);

    run(OP_BRANCH, 3'b001, 1'b1, 1'b0, 0, 12);
    chk("bne_z1_cycles", 32'(ncyc), 32'd3);
    chk("bne_z1_pc", 32'(pcv[2]), 32'd0);
    run(OP_BRANCH, 3'b001, 1'b0, 1'b0, 0, 12);
    chk("bne_z0_pc", 32'(pcv[2]), 32'd1);
    run(OP_BRANCH, 3'b111, 1'b0, 1'b0, 0, 12);
    chk("bgeu_lt0_pc", 32'(pcv[2]), 32'd1);
    run(OP_BRANCH, 3'b111, 1'b0, 1'b1, 0, 12);
    chk("bgeu_lt1_pc", 32'(pcv[2]), 32'd0);
    run(OP_BRANCH, 3'b000, 1'b1, 1'b0, 0, 12);
    chk("beq_z1_pc", 32'(pcv[2]), 32'd1);
    run(OP_BRANCH, 3'b100, 1'b0, 1'b1, 0, 12);
    chk("blt_lt1_pc", 32'(pcv[2]), 32'd1);
    chk("blt_aluop", 32'(aop[2]), 32'd1);
    run(OP_BRANCH, 3'b010, 1'b1, 1'b1, 0, 12);
    chk("br_f3_010_pc", 32'(pcv[2]), 32'd0);

    run(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 12);
    chk("jal_cycles", 32'(ncyc), 32'd4);
    chk("jal_pc_count", 32'(npc), 32'd2);
    chk("jal_rw_count", 32'(nrw), 32'd1);

    run(OP_JALR, 3'b000, 1'b0, 1'b0, 0, 12);
    chk("jalr_cycles", 32'(ncyc), 32'd5);
    chk("jalr_s2", 32'(seq[2]), 32'(JALR));
    chk("jalr_s3", 32'(seq[3]), 32'(JAL));
    chk("jalr_s4", 32'(seq[4]), 32'(ALUWB));
    chk("jalr_pc_fetch", 32'(pcv[0]), 32'd1);
    chk("jalr_pc_jal", 32'(pcv[3]), 32'd1);
    chk("jalr_pc_count", 32'(npc), 32'd2);
    chk("jalr_rw_aluwb", 32'(rwv[4]), 32'd1);
    chk("jalr_rw_count", 32'(nrw), 32'd1);

    run(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 12);
    chk("lui_cycles", 32'(ncyc), 32'd4);
    chk("lui_aluop", 32'(aop[2]), 32'd3);

    // reset asserted while a store is stalled in MEMWRITE
    bus.op = OP_STORE; bus.mem_ready = 1'b1;
    nxt(); nxt(); nxt();
    bus.mem_ready = 1'b0;
    #1;
    chk("mw_write_pre", 32'(bus.mem_write), 32'd1);
    nxt();
    rst_n = 1'b0;
    #1;
    chk("mw_rst_write", 32'(bus.mem_write), 32'd0);
    chk("mw_rst_req", 32'(bus.mem_req), 32'd0);
    chk("mw_rst_state", 32'(dut.state_q), 32'(FETCH));
    chk("mw_rst_illegal", 32'(bus.illegal_instr), 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 6);
    chk("ill_no_return", 32'(ncyc), 32'd6);
    chk("ill_trap", 32'(seq[2]), 32'(TRAP));
    chk("ill_flag", 32'(bus.illegal_instr), 32'd1);
    chk("ill_no_rw", 32'(nrw), 32'd0);
    nxt(); nxt();
    chk("ill_sticky", 32'(bus.illegal_instr), 32'd1);
    chk("ill_no_req", 32'(bus.mem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("ill_rst_clear", 32'(bus.illegal_instr), 32'd0);
    chk("ill_rst_state", 32'(dut.state_q), 32'(FETCH));
    @(negedge clk) rst_n = 1'b1;
`else
    run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 6);
    chk("ill_nop_cycles", 32'(ncyc), 32'd2);
    chk("ill_nop_rw", 32'(nrw), 32'd0);
    chk("ill_nop_mw", 32'(nmw), 32'd0);
    chk("ill_nop_flag", 32'(bus.illegal_instr), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports in this order: clk (in, 1, rising-edge clock), then rst_n (in, 1, async active-low reset).
REQ-002 SHALL have inputs: op (in, 7, opcode), funct3 (in, 3, branch condition), zero (in, 1, ALU result==0), lt (in, 1, ALU result bit0 from SLT/SLTU), mem_ready (in, 1, memory completes current request).
REQ-003 SHALL have request/strobe outputs: mem_req (out, 1, memory access active), mem_write (out, 1, store strobe), ir_write (out, 1, IR load), pc_update (out, 1, PC load), reg_write (out, 1, register file write).
REQ-004 SHALL have select outputs:
- adr_src (out, 1): 0=PC, 1=ALUOut.
- alu_src_a (out, 2): 00=PC, 01=oldPC, 10=rs1.
- alu_src_b (out, 2): 00=rs2, 01=imm, 10=const 4.
- result_src (out, 2): 00=ALUOut, 01=read data, 10=ALU result.
- ALUOp (out, 2): consumed by the ALU control decoder.
REQ-005 SHALL have illegal_instr (out, 1, sticky illegal-opcode flag).

Function
REQ-010 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP; all outputs decoded from state only, except that strobes are qualified by mem_ready and branch outcome.
REQ-011 SHALL, in FETCH, drive mem_req=1, adr_src=0, a=00, b=10, ALUOp=00, result_src=10, and assert ir_write=pc_update=mem_ready; it SHALL hold FETCH while mem_ready=0 and move to DECODE on mem_ready=1.
REQ-012 SHALL, in DECODE, drive a=01, b=01, ALUOp=00 (branch/JAL target into ALUOut), then dispatch on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 or 0010111 -> UPPER
- otherwise -> per REQ-040.
REQ-013 SHALL, in MEMADR, drive a=10, b=01, ALUOp=00, then go to MEMREAD for a load or MEMWRITE for a store.
REQ-014 SHALL, in MEMREAD, drive mem_req=1, adr_src=1, hold until mem_ready=1, then go to MEMWB.
REQ-015 SHALL, in MEMWB, drive result_src=01, reg_write=1, then go to FETCH.
REQ-016 SHALL, in MEMWRITE, drive mem_req=1, adr_src=1, mem_write=1, hold until mem_ready=1, then go to FETCH.
REQ-017 SHALL use a=10 with ALUOp=10 in EXECR (b=00) and EXECI (b=01), then go to ALUWB.
REQ-018 SHALL, in ALUWB, drive result_src=00, reg_write=1, then go to FETCH.
REQ-019 SHALL, in BRANCH, drive a=10, b=00, ALUOp=01, result_src=00, then go to FETCH. pc_update=take, where take is:
- funct3 000: zero
- funct3 001: !zero
- funct3 100 or 110: lt
- funct3 101 or 111: !lt
- other funct3: 0
REQ-020 SHALL, in JALR, drive a=10, b=01, ALUOp=00, then go to JAL.
REQ-021 SHALL, in JAL, drive a=01, b=10, ALUOp=00, result_src=00, pc_update=1, then go to ALUWB.
REQ-022 SHALL, in UPPER, drive a=01, b=01, ALUOp=11, then go to ALUWB.
REQ-023 SHALL, in any state where they are not listed above, hold strobes at 0 and selects at 0.
REQ-024 SHALL give these latencies with mem_ready tied to 1:
- R/I-type, LUI/AUIPC: 4 cycles
- load: 5 cycles
- store: 4 cycles
- branch: 3 cycles
- JAL: 4 cycles
- JALR: 5 cycles
REQ-025 SHALL extend a memory state by exactly one cycle per cycle of mem_ready=0.

Reset
REQ-030 SHALL, while rst_n=0, force the state to FETCH asynchronously.
REQ-031 SHALL, while rst_n=0, force every strobe and mem_req to 0, force selects to their FETCH values, and clear illegal_instr.
REQ-032 SHALL return to FETCH if reset is asserted mid-instruction (including MEMWRITE), with mem_write dropping in the same cycle as reset assertion.

Configuration
REQ-040 SHALL, with MAIN_CTRL_ILLEGAL_TRAP_EN defined, send an undefined op in DECODE to TRAP, which sets illegal_instr=1, drives all strobes 0, and holds until reset.
REQ-041 SHALL, without MAIN_CTRL_ILLEGAL_TRAP_EN, execute an undefined op as a NOP (DECODE -> FETCH), with illegal_instr tied to 0 and the TRAP state absent.

Structure
REQ-050 SHALL take the state enum, opcode constants, ALUOp encodings and mux-select encodings from shared package rv_ctrl_pkg.
REQ-051 SHALL implement the branch condition as sub-module branch_cond (funct3, zero, lt -> take).

Verification
REQ-060 Reset: rst_n=0 mid-MEMWRITE -> mem_write=0 immediately, state FETCH, illegal_instr=0.
REQ-061 add (op=0110011), mem_ready=1 -> 4 cycles, ALUOp=10 in EXECR, single reg_write pulse in cycle 4.
REQ-062 lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles, reg_write in MEMWB, total 8 cycles.
REQ-063 Branch decisions:
- bne with zero=1 -> pc_update=0 in BRANCH
- bne with zero=0 -> pc_update=1
- bgeu with lt=0 -> pc_update=1
REQ-064 jalr -> sequence FETCH, DECODE, JALR, JAL, ALUWB; pc_update pulses in FETCH and JAL, reg_write in ALUWB.
REQ-065 op=1111111 -> with MAIN_CTRL_ILLEGAL_TRAP_EN, TRAP entered and illegal_instr=1 sticky; without it, returns to FETCH after 2 cycles with no writes.
